// File: rtl/riscv_pipe_pkg.sv
// Shared constants, encodings and helpers for the RV32I pipeline stages.
// Used by id_ex_stage and fwd_mux3.
package riscv_pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // ALU operation codes driven on ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

    // Op codes outside the implemented set make the ALU return zero
    function automatic logic is_illegal_aluop(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/fwd_mux3.sv
// Three-input forwarding selector; the reserved select falls back to input 0.
module fwd_mux3 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] y
);
    import riscv_pipe_pkg::*;

    always_comb begin
        y = in0;
        case (fwd_sel_e'(sel))
            FWD_WB:  y = in1;
            FWD_MEM: y = in2;
            default: y = in0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side operand forwarding.
// Optional registered illegal ALU op flag enabled by ILLEGAL_ALUOP_CHK_EN.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic [XLEN-1:0]       rd1_d,
    input  logic [XLEN-1:0]       rd2_d,
    input  logic [XLEN-1:0]       imm_ext_d,
    input  logic [XLEN-1:0]       pc_d,
    input  logic [XLEN-1:0]       pc_plus4_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic [2:0]            alu_control_d,
    input  logic                  alu_src_d,
    input  logic                  reg_write_d,
    input  logic                  mem_write_d,
    input  logic                  branch_d,
    input  logic                  jump_d,
    input  logic [1:0]            result_src_d,
    input  logic                  valid_d,
    input  logic [1:0]            forward_a_e,
    input  logic [1:0]            forward_b_e,
    input  logic [XLEN-1:0]       alu_result_m,
    input  logic [XLEN-1:0]       result_w,
    output logic [XLEN-1:0]       src_a_e,
    output logic [XLEN-1:0]       src_b_e,
    output logic [2:0]            alu_control_e,
    output logic [XLEN-1:0]       write_data_e,
    output logic [XLEN-1:0]       imm_ext_e,
    output logic [XLEN-1:0]       pc_e,
    output logic [XLEN-1:0]       pc_plus4_e,
    output logic [REG_ADDR_W-1:0] rs1_e,
    output logic [REG_ADDR_W-1:0] rs2_e,
    output logic [REG_ADDR_W-1:0] rd_e,
    output logic                  reg_write_e,
    output logic                  mem_write_e,
    output logic                  branch_e,
    output logic                  jump_e,
    output logic [1:0]            result_src_e,
    output logic                  valid_e,
    output logic                  illegal_op_e
);
    import riscv_pipe_pkg::*;

    typedef struct packed {
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [XLEN-1:0]       imm_ext;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pc_plus4;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            alu_control;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic [1:0]            result_src;
        logic                  valid;
    } id_ex_t;

    id_ex_t d_fields;
    id_ex_t q_fields;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    always_comb begin
        d_fields.rd1         = rd1_d;
        d_fields.rd2         = rd2_d;
        d_fields.imm_ext     = imm_ext_d;
        d_fields.pc          = pc_d;
        d_fields.pc_plus4    = pc_plus4_d;
        d_fields.rs1         = rs1_d;
        d_fields.rs2         = rs2_d;
        d_fields.rd          = rd_d;
        d_fields.alu_control = alu_control_d;
        d_fields.alu_src     = alu_src_d;
        d_fields.reg_write   = reg_write_d;
        d_fields.mem_write   = mem_write_d;
        d_fields.branch      = branch_d;
        d_fields.jump        = jump_d;
        d_fields.result_src  = result_src_d;
        d_fields.valid       = valid_d;
    end

    // A bubble is all-zero: ADD, no writes, not valid.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            q_fields <= '0;
        end else if (!stall_e) begin
            q_fields <= d_fields;
        end
    end

`ifdef ILLEGAL_ALUOP_CHK_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            illegal_q <= 1'b0;
        end else if (!stall_e) begin
            illegal_q <= valid_d && is_illegal_aluop(alu_control_d);
        end
    end

    assign illegal_op_e = illegal_q;
`else
    assign illegal_op_e = 1'b0;
`endif

    // Forwarding stays live while stalled so held operands see late results.
    fwd_mux3 #(.WIDTH(XLEN)) u_fwd_a (
        .sel (forward_a_e),
        .in0 (q_fields.rd1),
        .in1 (result_w),
        .in2 (alu_result_m),
        .y   (fwd_a)
    );

    fwd_mux3 #(.WIDTH(XLEN)) u_fwd_b (
        .sel (forward_b_e),
        .in0 (q_fields.rd2),
        .in1 (result_w),
        .in2 (alu_result_m),
        .y   (fwd_b)
    );

    assign src_a_e       = fwd_a;
    assign src_b_e       = q_fields.alu_src ? q_fields.imm_ext : fwd_b;
    assign write_data_e  = fwd_b;
    assign alu_control_e = q_fields.alu_control;
    assign imm_ext_e     = q_fields.imm_ext;
    assign pc_e          = q_fields.pc;
    assign pc_plus4_e    = q_fields.pc_plus4;
    assign rs1_e         = q_fields.rs1;
    assign rs2_e         = q_fields.rs2;
    assign rd_e          = q_fields.rd;
    assign reg_write_e   = q_fields.reg_write;
    assign mem_write_e   = q_fields.mem_write;
    assign branch_e      = q_fields.branch;
    assign jump_e        = q_fields.jump;
    assign result_src_e  = q_fields.result_src;
    assign valid_e       = q_fields.valid;

endmodule
